// File: rtl/fetch_sequencer.sv
// fetch_sequencer: command-driven controller for the instruction-fetch stage.
// It decodes UART command bytes, streams a length-prefixed program into
// instruction memory through the bootloader byte port, and sequences the PC
// (free-run with watchdog, single-step, PC clear).
`timescale 1ns/1ps
module fetch_sequencer #(
  parameter int unsigned           NB_BYTE        = 8,
  parameter int unsigned           NB_LEN         = 16,
  parameter int unsigned           NB_TIMEOUT     = 24,
  parameter logic [NB_TIMEOUT-1:0] TIMEOUT_CYCLES = 24'hFFFFFF
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_BYTE-1:0] i_rx_data,
  input  logic               i_rx_valid,
  input  logic               i_is_end,
  output logic [NB_BYTE-1:0] o_byte_de_bootloader,
  output logic               o_bootloader_write_enable,
  output logic               o_pc_enable,
  output logic               o_pc_reset,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_timeout,
  output logic               o_cmd_error,
  output logic [2:0]         o_state
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_LOAD   = 3'd3,
    ST_RUN    = 3'd4,
    ST_STEP   = 3'd5,
    ST_FINISH = 3'd6
  } state_t;

  localparam logic [NB_BYTE-1:0]    CMD_LOAD  = NB_BYTE'(8'h4C);
  localparam logic [NB_BYTE-1:0]    CMD_RUN   = NB_BYTE'(8'h52);
  localparam logic [NB_BYTE-1:0]    CMD_STEP  = NB_BYTE'(8'h53);
  localparam logic [NB_BYTE-1:0]    CMD_PCRST = NB_BYTE'(8'h50);
  localparam logic [NB_TIMEOUT-1:0] WDOG_LAST = TIMEOUT_CYCLES - NB_TIMEOUT'(1);

  state_t              state_q, state_d;
  logic [NB_BYTE-1:0]  len_hi_q, len_hi_d;
  logic [NB_LEN-1:0]   remaining_q, remaining_d;
  logic [NB_TIMEOUT-1:0] wdog_q, wdog_d;
  logic [NB_BYTE-1:0]  wr_byte_q, wr_byte_d;
  logic                wr_en_q, wr_en_d;

  logic [NB_LEN-1:0]   rx_length;
  logic                wdog_hit;
  logic                idle_cmd;

  assign rx_length = NB_LEN'({len_hi_q, i_rx_data});
  assign wdog_hit  = (wdog_q == WDOG_LAST);
  assign idle_cmd  = (state_q == ST_IDLE) && i_rx_valid;

  // State register and datapath flops; reset aborts any load or run at once.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= ST_IDLE;
      len_hi_q    <= '0;
      remaining_q <= '0;
      wdog_q      <= '0;
      wr_byte_q   <= '0;
      wr_en_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_hi_q    <= len_hi_d;
      remaining_q <= remaining_d;
      wdog_q      <= wdog_d;
      wr_byte_q   <= wr_byte_d;
      wr_en_q     <= wr_en_d;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d     = state_q;
    len_hi_d    = len_hi_q;
    remaining_d = remaining_q;
    wdog_d      = '0;
    wr_byte_d   = wr_byte_q;
    wr_en_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_rx_valid) begin
          case (i_rx_data)
            CMD_LOAD: state_d = ST_LEN_HI;
            CMD_RUN:  state_d = ST_RUN;
            CMD_STEP: state_d = ST_STEP;
            default:  state_d = ST_IDLE;
          endcase
        end
      end
      ST_LEN_HI: begin
        if (i_rx_valid) begin
          len_hi_d = i_rx_data;
          state_d  = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (i_rx_valid) begin
          if (rx_length == '0) begin
            state_d = ST_FINISH;
          end else begin
            remaining_d = rx_length;
            state_d     = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (i_rx_valid) begin
          wr_byte_d = i_rx_data;
          wr_en_d   = 1'b1;
          if (remaining_q != '0) begin
            remaining_d = remaining_q - NB_LEN'(1);
          end
          if (remaining_q <= NB_LEN'(1)) begin
            state_d = ST_FINISH;
          end
        end
      end
      ST_RUN: begin
        wdog_d = wdog_q + NB_TIMEOUT'(1);
        if (i_is_end || wdog_hit) begin
          state_d = ST_IDLE;
        end
      end
      ST_STEP:   state_d = ST_IDLE;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output decode; pulses are Mealy on the state and the current inputs.
  always_comb begin
    o_pc_enable = 1'b0;
    o_pc_reset  = 1'b0;
    o_done      = 1'b0;
    o_timeout   = 1'b0;
    o_cmd_error = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (idle_cmd) begin
          if (i_rx_data == CMD_PCRST) begin
            o_pc_reset = 1'b1;
            o_done     = 1'b1;
          end else if ((i_rx_data != CMD_LOAD) && (i_rx_data != CMD_RUN) &&
                       (i_rx_data != CMD_STEP)) begin
            o_cmd_error = 1'b1;
          end
        end
      end
      ST_RUN: begin
        o_pc_enable = !i_is_end;
        o_done      = i_is_end;
        o_timeout   = !i_is_end && wdog_hit;
      end
      ST_STEP: begin
        o_pc_enable = !i_is_end;
        o_done      = 1'b1;
      end
      ST_FINISH: begin
        o_pc_reset = 1'b1;
        o_done     = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_busy                    = (state_q != ST_IDLE);
  assign o_state                   = state_q;
  assign o_byte_de_bootloader      = wr_byte_q;
  assign o_bootloader_write_enable = wr_en_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: write bytes are scoreboarded with
// their expected cycle; pulse outputs are counted per scenario and checked.
`timescale 1ns/1ps
module tb_fetch_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic       is_end = 1'b0;

  logic [7:0] wr_byte;
  logic       wr_en, pc_en, pc_rst, busy, done, tout, cmd_err;
  logic [2:0] state;

  fetch_sequencer #(
    .NB_BYTE       (8),
    .NB_LEN        (16),
    .NB_TIMEOUT    (24),
    .TIMEOUT_CYCLES(24'd16)
  ) dut (
    .i_clk                    (clk),
    .i_reset                  (rst_n),
    .i_rx_data                (rx_data),
    .i_rx_valid               (rx_valid),
    .i_is_end                 (is_end),
    .o_byte_de_bootloader     (wr_byte),
    .o_bootloader_write_enable(wr_en),
    .o_pc_enable              (pc_en),
    .o_pc_reset               (pc_rst),
    .o_busy                   (busy),
    .o_done                   (done),
    .o_timeout                (tout),
    .o_cmd_error              (cmd_err),
    .o_state                  (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    int unsigned cyc;
  } wr_t;

  wr_t         exp_q[$];
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  int unsigned n_we, n_pcen, n_pcrst, n_done, n_tout, n_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic clr_counts();
    n_we = 0; n_pcen = 0; n_pcrst = 0; n_done = 0; n_tout = 0; n_err = 0;
  endtask

  task automatic send(input logic [7:0] b, input bit is_data);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    if (is_data) exp_q.push_back('{b, cyc + 1});
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en) begin
        n_we++;
        if (exp_q.size() == 0) begin
          check("wr_unexpected", 32'd1, 32'd0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_byte", wr_byte, e.data);
          check("wr_cycle", cyc, e.cyc);
        end
      end
      if (pc_en) begin
        n_pcen++;
        check("pcen_vs_pcrst", pc_rst, 1'b0);
      end
      if (pc_rst) begin
        n_pcrst++;
        check("pcrst_with_done", done, 1'b1);
      end
      if (done) n_done++;
      if (tout) begin
        n_tout++;
        check("tout_no_done", done, 1'b0);
      end
      if (cmd_err) n_err++;
    end
  end

  initial begin
    clr_counts();
    // Reset held for 3 cycles.
    repeat (3) @(posedge clk);
    #1;
    check("rst_outs", {wr_byte, wr_en, pc_en, pc_rst, busy, done, tout, cmd_err}, '0);
    check("rst_state", state, 3'd0);
    rst_n = 1'b1;
    idle(2);
    check("post_rst_outs", {wr_byte, wr_en, pc_en, pc_rst, busy, done, tout, cmd_err}, '0);

    // Four-byte load.
    clr_counts();
    send(8'h4C, 0); send(8'h00, 0); send(8'h04, 0);
    send(8'hAA, 1); send(8'hBB, 1); send(8'hCC, 1); send(8'hDD, 1);
    idle(4);
    check("load_we", n_we, 4);
    check("load_pcrst", n_pcrst, 1);
    check("load_done", n_done, 1);
    check("load_busy", busy, 1'b0);
    check("load_state", state, 3'd0);

    // Zero-length load.
    clr_counts();
    send(8'h4C, 0); send(8'h00, 0); send(8'h00, 0);
    idle(4);
    check("zlen_we", n_we, 0);
    check("zlen_pcrst", n_pcrst, 1);
    check("zlen_done", n_done, 1);

    // Run for 10 cycles, then end of program.
    clr_counts();
    send(8'h52, 0);
    check("run_state", state, 3'd4);
    repeat (10) @(posedge clk);
    #1 is_end = 1'b1;
    @(posedge clk);
    #1 is_end = 1'b0;
    idle(3);
    check("run_pcen", n_pcen, 10);
    check("run_done", n_done, 1);
    check("run_tout", n_tout, 0);
    check("run_state_end", state, 3'd0);

    // Run with end of program already high on entry.
    clr_counts();
    is_end = 1'b1;
    send(8'h52, 0);
    idle(2);
    is_end = 1'b0;
    idle(2);
    check("run_end0_pcen", n_pcen, 0);
    check("run_end0_done", n_done, 1);

    // Two steps, then a step at end of program.
    clr_counts();
    send(8'h53, 0); idle(2);
    send(8'h53, 0); idle(2);
    check("step_pcen", n_pcen, 2);
    check("step_done", n_done, 2);
    clr_counts();
    is_end = 1'b1;
    send(8'h53, 0); idle(2);
    is_end = 1'b0;
    idle(1);
    check("step_end_pcen", n_pcen, 0);
    check("step_end_done", n_done, 1);

    // Unknown command.
    clr_counts();
    send(8'h7A, 0); idle(2);
    check("err_count", n_err, 1);
    check("err_state", state, 3'd0);
    check("err_done", n_done, 0);

    // Watchdog expiry.
    clr_counts();
    send(8'h52, 0);
    idle(30);
    check("wd_tout", n_tout, 1);
    check("wd_pcen", n_pcen, 16);
    check("wd_done", n_done, 0);
    check("wd_state", state, 3'd0);

    // PC reset command.
    clr_counts();
    send(8'h50, 0); idle(2);
    check("pcrst_count", n_pcrst, 1);
    check("pcrst_done", n_done, 1);
    check("pcrst_pcen", n_pcen, 0);
    check("pcrst_state", state, 3'd0);

    // Reset mid-load with two bytes remaining.
    clr_counts();
    send(8'h4C, 0); send(8'h00, 0); send(8'h05, 0);
    send(8'h01, 1); send(8'h02, 1); send(8'h03, 1);
    idle(1);
    check("midload_state", state, 3'd3);
    check("midload_we", n_we, 3);
    rst_n = 1'b0;
    #1;
    check("midload_rst_state", state, 3'd0);
    check("midload_rst_busy", busy, 1'b0);
    clr_counts();
    idle(2);
    rst_n = 1'b1;
    idle(6);
    check("midload_after_we", n_we, 0);
    check("midload_after_done", n_done, 0);
    check("midload_after_pcrst", n_pcrst, 0);
    check("wr_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
